// File: rtl/lfsr_sng_pkg.sv
// -----------------------------------------------------------------------------
// sng_pkg -- shared definitions for the stochastic number generator family.
//
// Contents:
//   sng_state_t   : control FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   TAPS_W8/16    : maximal-length Fibonacci tap masks for common widths
//   DEFAULT_SEED  : nonzero LFSR reset state
//   default_taps  : helper returning the tap mask for a supported width
// -----------------------------------------------------------------------------
package sng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_t;

  // Primitive polynomials: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1.
  localparam logic [7:0]  TAPS_W8      = 8'hB8;
  localparam logic [15:0] TAPS_W16     = 16'hB400;
  localparam logic [7:0]  DEFAULT_SEED = 8'h01;

  // Returns zero for widths without a known primitive polynomial so that a
  // caller can detect the unsupported case.
  function automatic logic [31:0] default_taps(input int wl);
    logic [31:0] t;
    t = '0;
    case (wl)
      8:       t = 32'(TAPS_W8);
      16:      t = 32'(TAPS_W16);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_sng_if.sv
// -----------------------------------------------------------------------------
// lfsr_sng_if -- request/stream bundle between a producer (master) and the
// stochastic number generator (slave).
//
//   value     master->slave  WL  binary operand, sampled on accepted start
//   start     master->slave  1   request a stream
//   seed      master->slave  WL  new LFSR seed
//   seed_load master->slave  1   load seed (honoured only when idle)
//   bit_out   slave->master  1   stochastic bit, qualified by bit_valid
//   bit_valid slave->master  1   high for each stream bit
//   busy      slave->master  1   stream in progress
//   done      slave->master  1   one-cycle pulse after the last bit
//   ones_cnt  slave->master  CW  ones in the current/last stream
// -----------------------------------------------------------------------------
interface lfsr_sng_if #(
  parameter int WL = 8,
  parameter int CW = 8
);

  logic [WL-1:0] value;
  logic          start;
  logic [WL-1:0] seed;
  logic          seed_load;
  logic          bit_out;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_cnt;

  modport master (
    output value, start, seed, seed_load,
    input  bit_out, bit_valid, busy, done, ones_cnt
  );

  modport slave (
    input  value, start, seed, seed_load,
    output bit_out, bit_valid, busy, done, ones_cnt
  );

endinterface

// File: rtl/lfsr_sng_en_reg.sv
// -----------------------------------------------------------------------------
// en_reg -- enable-gated register with asynchronous active-low reset.
//
//   clk    in  1  clock
//   rst_b  in  1  asynchronous reset, active-low (q <= RST_VAL)
//   wen    in  1  write enable; q holds when low
//   d      in  W  data in
//   q      out W  registered data
// -----------------------------------------------------------------------------
module en_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= RST_VAL;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lfsr_sng_lfsr_fib.sv
// -----------------------------------------------------------------------------
// lfsr_fib -- Fibonacci LFSR, shifting left with the feedback entering bit 0.
//
//   clk      in  1   clock
//   rst_b    in  1   asynchronous reset, active-low (state <= SEED)
//   load     in  1   load load_val (has priority over step)
//   load_val in  WL  value to load; caller guarantees it is nonzero
//   step     in  1   advance one position
//   state    out WL  current register contents
//
// With a primitive TAPS mask and nonzero contents the register walks all
// 2^WL-1 nonzero states before repeating; zero is never entered.
// -----------------------------------------------------------------------------
module lfsr_fib
  import sng_pkg::*;
#(
  parameter int            WL   = 8,
  parameter logic [WL-1:0] TAPS = TAPS_W8,
  parameter logic [WL-1:0] SEED = DEFAULT_SEED
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          load,
  input  logic [WL-1:0] load_val,
  input  logic          step,
  output logic [WL-1:0] state
);

  logic          fb;
  logic [WL-1:0] next;

  assign fb   = ^(state & TAPS);
  assign next = {state[WL-2:0], fb};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/lfsr_sng.sv
// -----------------------------------------------------------------------------
// lfsr_sng -- stochastic number generator.
//
// Converts a WL-bit unsigned value into a unipolar stochastic stream of
// STREAM_LEN bits: each bit is 1 when the LFSR state is below the value.
// Over a full LFSR period (STREAM_LEN = 2^WL-1) the ones count is exactly
// max(value-1, 0), since every nonzero state is visited once.
//
//   clk    in  1  clock
//   rst_b  in  1  asynchronous reset, active-low
//   bus    slave modport of lfsr_sng_if (value/start/seed/seed_load in,
//          bit_out/bit_valid/busy/done/ones_cnt out)
//
// Timing: start accepted at edge t -> bits valid in cycles t+1..t+STREAM_LEN
// -> done pulse in cycle t+STREAM_LEN+1. All outputs are registered, so they
// trail the FSM state by one cycle.
// -----------------------------------------------------------------------------
module lfsr_sng
  import sng_pkg::*;
#(
  parameter int            WL         = 8,
  parameter logic [WL-1:0] TAPS       = TAPS_W8,
  parameter logic [WL-1:0] SEED       = DEFAULT_SEED,
  parameter int            STREAM_LEN = 255,
  parameter int            CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_b,
  lfsr_sng_if.slave  bus
);

  sng_state_t    state_q, state_d;
  logic          idle;
  logic          accept;
  logic          seed_wr;
  logic          last;
  logic          cmp;
  logic [WL-1:0] value_q;
  logic [WL-1:0] lfsr;
  logic [WL-1:0] seed_val;
  logic [CW-1:0] len_cnt;
  logic [CW-1:0] ones_cnt_q;
  logic          bit_out_q;
  logic          bit_valid_q;
  logic          busy_q;
  logic          done_q;

  assign idle    = (state_q == IDLE);
  assign accept  = idle & bus.start;
  assign seed_wr = idle & bus.seed_load;
  assign last    = (len_cnt == CW'(STREAM_LEN - 1));

  // A zero seed would lock the LFSR, so it falls back to the default state.
  assign seed_val = (bus.seed == '0) ? SEED : bus.seed;

  // Operand capture: only an accepted start writes it, so later changes on
  // the value input cannot disturb a stream in flight.
  en_reg #(
    .W       (WL),
    .RST_VAL ('0)
  ) u_value_reg (
    .clk   (clk),
    .rst_b (rst_b),
    .wen   (accept),
    .d     (bus.value),
    .q     (value_q)
  );

  // Load wins over step; both only happen in their own states, so a seed
  // loaded together with start becomes the first state compared.
  lfsr_fib #(
    .WL   (WL),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (seed_wr),
    .load_val (seed_val),
    .step     (state_q == RUN),
    .state    (lfsr)
  );

  assign cmp = (lfsr < value_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Registered outputs and counters, updated from the current FSM state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_cnt_q  <= '0;
      len_cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= accept;
          // ones_cnt keeps the last stream's result until the next start.
          if (accept) begin
            ones_cnt_q <= '0;
            len_cnt    <= '0;
          end
        end
        RUN: begin
          bit_out_q   <= cmp;
          bit_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
          ones_cnt_q  <= ones_cnt_q + CW'(cmp);
          len_cnt     <= len_cnt + CW'(1);
        end
        DONE: begin
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end
        default: begin
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ones_cnt  = ones_cnt_q;

endmodule

// File: tb/tb_lfsr_sng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_sng -- self-checking bench for lfsr_sng (WL=8, full-period streams).
// The reference model tracks the LFSR as a plain integer stepped by the
// shift/parity rule and derives each expected bit as (state < value); stream
// totals are additionally checked against the closed form max(value-1, 0).
// -----------------------------------------------------------------------------
module tb_lfsr_sng;

  localparam int WL = 8;
  localparam int SL = 255;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  lfsr_sng_if #(.WL(WL), .CW(CW)) bus ();

  lfsr_sng #(
    .WL         (WL),
    .TAPS       (8'hB8),
    .SEED       (8'h01),
    .STREAM_LEN (SL),
    .CW         (CW)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_lfsr;

  typedef struct {
    logic [7:0] value;
    bit         do_seed;
    logic [7:0] seed;
    int         exp_ones;
  } vec_t;

  vec_t vecs[7];

  function automatic int m_step(input int s);
    int fb;
    fb = $countones(s & 32'hB8) % 2;
    return ((s * 2) % 256) + fb;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic load_seed(input logic [7:0] sd);
    @(negedge clk);
    bus.seed      = sd;
    bus.seed_load = 1'b1;
    @(posedge clk);
    m_lfsr = (sd == 8'h00) ? 1 : int'(sd);
    #1 bus.seed_load = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] v, input bit do_seed, input logic [7:0] sd,
                            input bit disturb, input int exp_ones,
                            output logic b0, output logic b1);
    int   m_ones;
    int   bad;
    int   mval;
    logic exp_bit;
    b0 = 1'bx;
    b1 = 1'bx;
    @(negedge clk);
    bus.value     = v;
    bus.start     = 1'b1;
    bus.seed_load = do_seed;
    bus.seed      = sd;
    @(posedge clk);
    if (do_seed) m_lfsr = (sd == 8'h00) ? 1 : int'(sd);
    mval   = int'(v);
    m_ones = 0;
    bad    = 0;
    #1;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k <= SL; k++) begin
      @(posedge clk);
      #1;
      exp_bit = (m_lfsr < mval);
      m_lfsr  = m_step(m_lfsr);
      m_ones += int'(exp_bit);
      if (k == 1) b0 = bus.bit_out;
      if (k == 2) b1 = bus.bit_out;
      if (bus.bit_valid !== 1'b1 || bus.bit_out !== exp_bit || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        if (bad == 0)
          $display("FAIL stream_bit k=%0d v=%0d: got valid=%b bit=%b done=%b busy=%b, required valid=1 bit=%b done=0 busy=1",
                   k, v, bus.bit_valid, bus.bit_out, bus.done, bus.busy, exp_bit);
        bad++;
      end
      if (disturb && k == 100) begin
        bus.start     = 1'b1;
        bus.value     = 8'd3;
        bus.seed_load = 1'b1;
        bus.seed      = 8'h77;
      end
      if (disturb && k == 101) begin
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
      end
    end
    check("stream_bit_errors", bad, 0);
    @(posedge clk);
    #1;
    check("done_pulse",       {31'b0, bus.done},      32'd1);
    check("valid_at_done",    {31'b0, bus.bit_valid}, 32'd0);
    check("busy_at_done",     {31'b0, bus.busy},      32'd0);
    check("ones_vs_model",    32'(bus.ones_cnt),      m_ones);
    check("ones_closed_form", 32'(bus.ones_cnt),      exp_ones);
    @(posedge clk);
    #1;
    check("done_single",      {31'b0, bus.done},      32'd0);
    check("ones_held",        32'(bus.ones_cnt),      exp_ones);
  endtask

  initial begin
    logic b0, b1;
    int   seen_done;
    logic [7:0] rv;

    vecs[0] = '{8'd128, 1'b0, 8'h00, 127};
    vecs[1] = '{8'd0,   1'b0, 8'h00, 0};
    vecs[2] = '{8'd255, 1'b0, 8'h00, 254};
    vecs[3] = '{8'd1,   1'b0, 8'h00, 0};
    vecs[4] = '{8'd200, 1'b1, 8'h5A, 199};
    vecs[5] = '{8'd64,  1'b0, 8'h00, 63};
    vecs[6] = '{8'd2,   1'b1, 8'hFF, 1};

    bus.value     = '0;
    bus.start     = 1'b0;
    bus.seed      = '0;
    bus.seed_load = 1'b0;
    rst_b         = 1'b0;

    // Reset defaults
    #12;
    check("rst_bit_out",   {31'b0, bus.bit_out},   32'd0);
    check("rst_bit_valid", {31'b0, bus.bit_valid}, 32'd0);
    check("rst_busy",      {31'b0, bus.busy},      32'd0);
    check("rst_done",      {31'b0, bus.done},      32'd0);
    check("rst_ones",      32'(bus.ones_cnt),      32'd0);
    check("rst_lfsr",      32'(dut.u_lfsr.state),  32'h01);
    @(negedge clk);
    rst_b  = 1'b1;
    m_lfsr = 1;

    // Table-driven full-period streams
    foreach (vecs[i])
      run_stream(vecs[i].value, vecs[i].do_seed, vecs[i].seed, 1'b0, vecs[i].exp_ones, b0, b1);

    // Zero seed falls back to the default state
    load_seed(8'h00);
    #1 check("zero_seed_lfsr", 32'(dut.u_lfsr.state), 32'h01);

    // Disturbances during RUN are ignored
    run_stream(8'd128, 1'b0, 8'h00, 1'b1, 127, b0, b1);

    // Simultaneous start + seed_load: states 0x80 then 0x01
    run_stream(8'h81, 1'b1, 8'h80, 1'b0, 128, b0, b1);
    check("first_bit_seeded",  {31'b0, b0}, 32'd1);
    check("second_bit_seeded", {31'b0, b1}, 32'd1);

    // Randomized full-period streams
    for (int r = 0; r < 4; r++) begin
      rv = 8'($urandom_range(0, 255));
      run_stream(rv, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0,
                 (rv == 8'd0) ? 0 : int'(rv) - 1, b0, b1);
    end

    // Reset in the middle of a stream
    @(negedge clk);
    bus.value = 8'd128;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    check("midrst_bit_out",   {31'b0, bus.bit_out},   32'd0);
    check("midrst_bit_valid", {31'b0, bus.bit_valid}, 32'd0);
    check("midrst_busy",      {31'b0, bus.busy},      32'd0);
    check("midrst_done",      {31'b0, bus.done},      32'd0);
    check("midrst_ones",      32'(bus.ones_cnt),      32'd0);
    check("midrst_lfsr",      32'(dut.u_lfsr.state),  32'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b     = 1'b1;
    m_lfsr    = 1;
    seen_done = 0;
    for (int c = 0; c < 260; c++) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1 || bus.bit_valid === 1'b1) seen_done++;
    end
    check("no_done_after_reset", seen_done, 0);
    run_stream(8'd128, 1'b0, 8'h00, 1'b0, 127, b0, b1);
    check("first_bit_from_seed", {31'b0, b0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
